// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with 2-entry FIFO, redirect flush, optional FETCH_PERF_CNT_EN stall counter
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] stall_cycles
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
  logic [1:0]  out_q, out_d, cnt_q, cnt_d, disc_q, disc_d;
  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        wr_q, wr_d, rd_q, rd_d;
  logic        acc, push, pop;
  assign imem_req    = !reset && state_q == RUN && !redirect && ({1'b0, out_q} + {1'b0, cnt_q} < 3'd2);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !reset && cnt_q != 2'd0;
  assign instr       = mem_q[rd_q];
  assign instr_pc    = head_pc_q;
  assign acc         = imem_req && imem_ready;
  assign push        = imem_rvalid && state_q == RUN && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  always_comb begin
    out_d      = out_q + {1'b0, acc} - {1'b0, imem_rvalid};
    fetch_pc_d = redirect ? redirect_pc : acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    head_pc_d  = redirect ? redirect_pc : pop ? head_pc_q + 32'd4 : head_pc_q;
    cnt_d      = redirect ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    wr_d       = redirect ? 1'b0 : wr_q ^ push;
    rd_d       = redirect ? 1'b0 : rd_q ^ pop;
    mem_d      = mem_q;
    mem_d[wr_q] = push ? imem_rdata : mem_q[wr_q];
    disc_d     = redirect ? out_d : (state_q == FLUSH && imem_rvalid) ? disc_q - 2'd1 : disc_q;
    state_d    = disc_d != 2'd0 ? FLUSH : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= '0;
      head_pc_q  <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      disc_q     <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      disc_q     <= disc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = (state_q == RUN && !instr_valid && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) stall_q <= reset ? '0 : stall_d;
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench with a queued instruction-memory model
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hDEAD0000;
`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd5;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif
  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ready, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, stall_cycles;
  logic [31:0] q [$];
  logic [31:0] exp_pc, exp_fetch;
  bit          hold;
  int          n_cmp, n_err, n_acc, n_pop;
  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic        a, p, rv;
    logic [31:0] ad;
    #1;
    a  = imem_req && imem_ready;
    p  = instr_valid && instr_ready && !redirect;
    rv = imem_rvalid;
    ad = imem_addr;
    if (a) begin
      chk("fetch_addr", ad, exp_fetch);
      exp_fetch += 32'd4;
      n_acc++;
    end
    if (p) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, exp_pc ^ K);
      exp_pc += 32'd4;
      n_pop++;
    end
    @(posedge clk);
    #1;
    if (reset) q.delete();
    else begin
      if (rv) void'(q.pop_front());
      if (a) q.push_back(ad);
    end
    imem_rvalid = !reset && !hold && q.size() > 0;
    imem_rdata  = imem_rvalid ? q[0] ^ K : 32'h0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    step();
    step();
    chk("rst_stall", stall_cycles, 0);
    reset = 1'b0;
    exp_pc = 0;
    exp_fetch = 0;
    n_acc = 0;
    n_pop = 0;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
  endtask
  initial begin
    reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1; hold = 1'b0;
    n_cmp = 0; n_err = 0;
    do_reset();
    step();
    chk("valid_c1", instr_valid, 0);
    step();
    chk("valid_c2", instr_valid, 1);
    chk("pc_c2", instr_pc, 32'h0);
    repeat (12) step();
    chk("stream_pops", n_pop >= 4, 1);
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    chk("full_reqs", n_acc, 2);
    chk("full_valid", instr_valid, 1);
    chk("full_req", imem_req, 0);
    chk("full_cnt", dut.cnt_q, 2);
    chk("full_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (10) step();
    chk("drain", exp_pc >= 8, 1);
    do_reset();
    hold = 1'b1;
    repeat (3) step();
    chk("outstanding2", dut.out_q, 2);
    chk("credit_req", imem_req, 0);
    redirect = 1'b1; redirect_pc = 32'h100; hold = 1'b0;
    exp_pc = 32'h100; exp_fetch = 32'h100;
    step();
    redirect = 1'b0;
    chk("flush_state", dut.state_q, 1);
    chk("flush_req", imem_req, 0);
    step();
    chk("flush_disc", dut.disc_q, 1);
    chk("flush_valid", instr_valid, 0);
    step();
    chk("run_state", dut.state_q, 0);
    chk("run_req", imem_req, 1);
    chk("run_addr", imem_addr, 32'h100);
    chk("run_valid", instr_valid, 0);
    n_pop = 0;
    repeat (8) step();
    chk("redir_pops", n_pop >= 2, 1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    exp_pc = 32'hFFFF_FFF8; exp_fetch = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (20) step();
    chk("wrap_fetch", exp_fetch >= 8 && exp_fetch < 32'h100, 1);
    chk("wrap_pc", exp_pc >= 4 && exp_pc < 32'h100, 1);
    do_reset();
    hold = 1'b1;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h200; hold = 1'b0;
    step();
    redirect = 1'b0; hold = 1'b1;
    step();
    chk("f2_disc", dut.disc_q, 1);
    chk("f2_state", dut.state_q, 1);
    redirect = 1'b1; redirect_pc = 32'h300;
    exp_pc = 32'h300; exp_fetch = 32'h300;
    step();
    redirect = 1'b0; hold = 1'b0;
    chk("f2_redisc", dut.disc_q, 1);
    chk("f2_restate", dut.state_q, 1);
    step();
    chk("f2_novalid", instr_valid, 0);
    step();
    chk("f2_run", dut.state_q, 0);
    chk("f2_valid", instr_valid, 0);
    chk("f2_addr", imem_addr, 32'h300);
    n_pop = 0;
    repeat (8) step();
    chk("f2_pops", n_pop >= 2, 1);
    do_reset();
    imem_ready = 1'b0;
    repeat (5) step();
    chk("stall_cnt", stall_cycles, STALL_EXP);
    chk("stall_req", imem_req, 1);
    chk("stall_acc", n_acc, 0);
    imem_ready = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 imem_req out 1: fetch request valid. imem_addr out 32: fetch word address. imem_ready in 1: memory accepts the request.
REQ-003 imem_rvalid in 1: response pulse, one per accepted request, in order, at least 1 cycle after acceptance. imem_rdata in 32: response word.
REQ-004 redirect in 1: taken branch / PC write (PCSrc). redirect_pc in 32: target address.
REQ-005 instr_valid out 1: instruction available. instr out 32: instruction word, feeds Instr[31:12] of the control path. instr_pc out 32: address of instr. instr_ready in 1: consumer takes instr.
REQ-006 stall_cycles out 32: fetch-starvation counter (see Configuration).

Function
REQ-007 State machine SHALL have states RUN and FLUSH; reset enters RUN.
REQ-008 Internal state: fetch_pc (32), outstanding count (0..2), 2-entry instruction FIFO, head_pc (32), discard_cnt (0..2).
REQ-009 imem_req SHALL be 1 only when all hold: state = RUN, redirect = 0, outstanding + FIFO count < 2.
REQ-010 imem_addr SHALL equal fetch_pc whenever imem_req = 1.
REQ-011 Acceptance (imem_req & imem_ready) SHALL increment outstanding and set fetch_pc <= fetch_pc + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-012 imem_rvalid SHALL decrement outstanding in the same cycle. Acceptance and response in the same cycle SHALL leave outstanding unchanged.
REQ-013 imem_rvalid in RUN with redirect = 0 SHALL push imem_rdata into the FIFO. The word is visible on instr the next cycle; there is no combinational bypass.
REQ-014 instr_valid SHALL equal FIFO non-empty. instr SHALL be the FIFO head. instr_pc SHALL be head_pc.
REQ-015 Pop SHALL occur on instr_valid & instr_ready, setting head_pc <= head_pc + 4 (mod 2^32).
REQ-016 Push and pop in the same cycle SHALL be legal, including at FIFO count 2. The credit rule in REQ-009 guarantees no overflow.
REQ-017 redirect = 1 SHALL, at the clock edge:
- clear the FIFO;
- set fetch_pc <= redirect_pc and head_pc <= redirect_pc;
- discard any response arriving that cycle;
- set discard_cnt <= outstanding remaining after that cycle;
- enter FLUSH if discard_cnt > 0, else RUN.
REQ-018 redirect SHALL take priority over a simultaneous pop, push or acceptance. imem_req is already 0 in that cycle.
REQ-019 In FLUSH: no requests are issued. Each imem_rvalid is dropped and decrements discard_cnt. Reaching 0 returns to RUN on that edge.
REQ-020 redirect during FLUSH SHALL re-apply REQ-017, with discard_cnt recomputed from outstanding.
REQ-021 A redirect target SHALL be fetched first after the flush: the first instr after a redirect has instr_pc = redirect_pc.

Reset
REQ-022 On reset:
- fetch_pc = 0, head_pc = 0, outstanding = 0, discard_cnt = 0, FIFO empty, state = RUN;
- imem_req = 0 and instr_valid = 0 during the reset cycle;
- stall_cycles = 0.
REQ-023 Reset mid-operation SHALL abandon all outstanding requests. The instruction memory SHALL be reset by the same reset signal, so no stale responses follow.
REQ-024 The first request after reset SHALL be issued in the first cycle with reset = 0, at imem_addr = 0x00000000.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN: when defined, stall_cycles SHALL increment in each cycle with reset = 0, state = RUN and instr_valid = 0. It saturates at 0xFFFFFFFF and clears only on reset.
REQ-026 Without FETCH_PERF_CNT_EN, stall_cycles SHALL be constant 0, the port SHALL remain present, and no counter logic SHALL be synthesized.

Verification
REQ-027 Reset, then imem_ready = 1 with 1-cycle latency and instr_ready = 1 -> imem_addr sequence 0,4,8,... and instr_pc matches the words returned, first instr_valid at cycle 2 after reset release.
REQ-028 instr_ready = 0 for 10 cycles -> exactly 2 requests issued, FIFO full, imem_req = 0. Releasing instr_ready -> in-order delivery with no loss or duplication.
REQ-029 redirect to 0x00000100 with 2 requests outstanding -> 2 responses dropped, state FLUSH then RUN, first delivered instr_pc = 0x00000100.
REQ-030 redirect_pc = 0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, with instr_pc wrapping identically.
REQ-031 redirect asserted in FLUSH with discard_cnt = 1 -> new target honoured, remaining stale response dropped, no stale instr_valid.
REQ-032 With FETCH_PERF_CNT_EN: imem_ready held 0 for 5 cycles after reset -> stall_cycles = 5. Without the macro -> stall_cycles = 0.
